lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 36 +++
 rtl/lsu.sv | 101 ++++++++++
 tb/tb_lsu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Request/response handshake and single-port RAM bus of the load/store unit.
// master = requester plus RAM side, slave = the LSU.
interface lsu_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error;
  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, ram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, ram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding byte/half/word access to a synchronous
// single-port RAM, with alignment checking and load lane extraction/extension.
module lsu #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic   clk,
  input logic   reset,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        misaligned;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] lane;
  logic [31:0] load_ext;

  always_comb begin
    unique case (bus.req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE) && !reset;
    bus.rsp_valid = (state == RESP) && !reset;
    accept        = bus.req_valid && bus.req_ready;
    bus.ram_en    = accept && !misaligned;
    bus.ram_addr  = bus.req_addr[ADDR_WIDTH+1:2];
    bus.ram_we    = '0;
    bus.ram_wdata = bus.req_wdata;
    unique case (bus.req_size)
      2'b00:   bus.ram_wdata = {4{bus.req_wdata[7:0]}};
      2'b01:   bus.ram_wdata = {2{bus.req_wdata[15:0]}};
      default: bus.ram_wdata = bus.req_wdata;
    endcase
    if (bus.ram_en && bus.req_we) begin
      unique case (bus.req_size)
        2'b00:   bus.ram_we = 4'b0001 << bus.req_addr[1:0];
        2'b01:   bus.ram_we = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        default: bus.ram_we = '1;
      endcase
    end
  end

  // The selected lane is shifted down to bit 0 before extension.
  always_comb begin
    lane = bus.ram_rdata >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   load_ext = {{24{~uns_q & lane[7]}}, lane[7:0]};
      2'b01:   load_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (misaligned || bus.req_we) ? RESP : WAIT;
      WAIT: state_nxt = RESP;
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_rdata <= '0;
      bus.rsp_error <= 1'b0;
      off_q         <= '0;
      size_q        <= '0;
      uns_q         <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        bus.rsp_rdata <= '0;
        bus.rsp_error <= misaligned;
        if (!misaligned && !bus.req_we) begin
          off_q  <= bus.req_addr[1:0];
          size_q <= bus.req_size;
          uns_q  <= bus.req_unsigned;
        end
      end else if (state == WAIT) begin
        bus.rsp_rdata <= load_ext;
        bus.rsp_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a behavioural synchronous RAM behind the bus.
module tb_lsu;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_WIDTH(10)) bus ();
  lsu #(.ADDR_WIDTH(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int i = 0; i < 4; i++)
        if (bus.ram_we[i]) mem[bus.ram_addr][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    #1;
  endtask

  task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] exp_we,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    send(1'b1, size, 1'b0, addr, wdata);
    check({tag, ".ram_en"}, {31'd0, bus.ram_en}, 32'd1);
    check({tag, ".ram_we"}, {28'd0, bus.ram_we}, {28'd0, exp_we});
    check({tag, ".ram_addr"}, {22'd0, bus.ram_addr}, exp_addr);
    check({tag, ".ram_wdata"}, bus.ram_wdata, exp_wdata);
    tick();
    bus.req_valid = 1'b0;
    check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, ".rsp_error"}, {31'd0, bus.rsp_error}, 32'd0);
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, ".busy"}, {31'd0, bus.req_ready}, 32'd0);
    tick();
    check({tag, ".idle"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [31:0] exp_data);
    send(1'b0, size, uns, addr, 32'h0);
    check({tag, ".ram_en"}, {31'd0, bus.ram_en}, 32'd1);
    check({tag, ".ram_we"}, {28'd0, bus.ram_we}, 32'd0);
    check({tag, ".ram_addr"}, {22'd0, bus.ram_addr}, exp_addr);
    tick();
    bus.req_valid = 1'b0;
    check({tag, ".wait"}, {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_data);
    check({tag, ".rsp_error"}, {31'd0, bus.rsp_error}, 32'd0);
    tick();
    check({tag, ".idle"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic do_bad(input string tag, input logic we, input logic [1:0] size,
                        input logic [31:0] addr);
    send(we, size, 1'b0, addr, 32'hFFFF_FFFF);
    check({tag, ".ram_en"}, {31'd0, bus.ram_en}, 32'd0);
    check({tag, ".ram_we"}, {28'd0, bus.ram_we}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    check({tag, ".rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, ".rsp_error"}, {31'd0, bus.rsp_error}, 32'd1);
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, 32'd0);
    tick();
    check({tag, ".idle"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    send(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678);

    // Reset with a pending request: nothing may be accepted or written.
    check("rst.req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst.ram_en", {31'd0, bus.ram_en}, 32'd0);
    check("rst.ram_we", {28'd0, bus.ram_we}, 32'd0);
    tick();
    tick();
    check("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst.rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst.rsp_error", {31'd0, bus.rsp_error}, 32'd0);
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rst.release_ready", {31'd0, bus.req_ready}, 32'd1);

    do_store("st_word", 2'b10, 32'h4, 32'h12FF_3456, 4'b1111, 32'd1, 32'h12FF_3456);
    do_store("st_byte", 2'b00, 32'h6, 32'h0000_00AB, 4'b0100, 32'd1, 32'hABAB_ABAB);
    check("mem1.after_byte", mem[1], 32'h12AB_3456);
    do_store("st_half", 2'b01, 32'hA, 32'h1234_BEEF, 4'b1100, 32'd2, 32'hBEEF_BEEF);
    check("mem2.upper", {16'd0, mem[2][31:16]}, 32'h0000_BEEF);

    do_load("ld_b_s",   2'b00, 1'b0, 32'h6, 32'd1, 32'hFFFF_FFAB);
    do_load("ld_b_u",   2'b00, 1'b1, 32'h6, 32'd1, 32'h0000_00AB);
    do_load("ld_h_hi",  2'b01, 1'b0, 32'h6, 32'd1, 32'h0000_12AB);
    do_load("ld_b0",    2'b00, 1'b0, 32'h4, 32'd1, 32'h0000_0056);
    do_load("ld_w",     2'b10, 1'b0, 32'h4, 32'd1, 32'h12AB_3456);

    do_store("st_w2", 2'b10, 32'h4, 32'h0000_8001, 4'b1111, 32'd1, 32'h0000_8001);
    do_load("ld_h_s",   2'b01, 1'b0, 32'h4, 32'd1, 32'hFFFF_8001);
    do_load("ld_h_u",   2'b01, 1'b1, 32'h4, 32'd1, 32'h0000_8001);
    do_load("ld_b1_s",  2'b00, 1'b0, 32'h5, 32'd1, 32'hFFFF_FF80);
    do_load("ld_wrap",  2'b10, 1'b0, 32'h0000_1004, 32'd1, 32'h0000_8001);

    do_bad("bad_word", 1'b0, 2'b10, 32'h2);
    do_bad("bad_size", 1'b0, 2'b11, 32'h0);
    do_bad("bad_st_h", 1'b1, 2'b01, 32'h5);
    check("mem1.untouched", mem[1], 32'h0000_8001);

    // Response held off while a new request waits at the input.
    bus.rsp_ready = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    tick();
    send(1'b1, 2'b00, 1'b0, 32'h4, 32'h0000_0077);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("bp.rsp_rdata", bus.rsp_rdata, 32'h0000_8001);
      check("bp.req_ready", {31'd0, bus.req_ready}, 32'd0);
      check("bp.ram_en", {31'd0, bus.ram_en}, 32'd0);
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    check("bp.consume_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    check("bp.after_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("bp.after_ready", {31'd0, bus.req_ready}, 32'd1);
    check("bp.mem1", mem[1], 32'h0000_8001);

    // Reset while the load is in WAIT.
    send(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rw.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rw.req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    check("rw.rsp_rdata", bus.rsp_rdata, 32'd0);
    reset = 1'b0;
    #1;
    check("rw.ready", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rw.no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
